// File: rtl/sram_mbist_pkg.sv
// rtl/sram_mbist_pkg.sv - shared types and March C- tables for the SRAM BIST controller
package sram_mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic {
    BG_SOLID,
    BG_CHECKER
  } bg_t;

  localparam int NUM_ELEMS = 6;
  localparam int ELEM_W    = 3;

  // One bit per element, bit i = element Mi: M0 w0 | M1 r0w1 | M2 r1w0 | M3 r0w1 | M4 r1w0 | M5 r0
  localparam logic [NUM_ELEMS-1:0] ELEM_DOWN = 6'b111000;
  localparam logic [NUM_ELEMS-1:0] ELEM_TWO  = 6'b011110;
  localparam logic [NUM_ELEMS-1:0] ELEM_RD0  = 6'b111110;
  localparam logic [NUM_ELEMS-1:0] ELEM_POL0 = 6'b010100;
  localparam logic [NUM_ELEMS-1:0] ELEM_POL1 = 6'b001010;

  localparam logic [1:0] CHK_EVEN_PAIR = 2'b01;

endpackage

// File: rtl/sram_mbist_cmp.sv
// rtl/sram_mbist_cmp.sv - read-data compare stage with sticky fail and first-fail capture
module sram_mbist_cmp #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] q,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_q
);

  logic              pend;
  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] pend_addr;
  logic              mis;

  assign mis = pend && (|(q ^ pend_data));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_data <= '0;
      pend_addr <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_q    <= '0;
    end else if (clr) begin
      pend      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_q    <= '0;
    end else begin
      pend      <= rd_issue;
      pend_data <= exp_data;
      pend_addr <= exp_addr;
      if (mis) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= pend_addr;
          fail_q    <= q;
        end
      end
    end
  end

endmodule

// File: rtl/sram_mbist_ctrl.sv
// rtl/sram_mbist_ctrl.sv - March C- BIST engine driving the SRAM macro BIST port
// Runs the six march elements over a solid then a checkerboard background.
module sram_mbist_ctrl
  import sram_mbist_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_q,
  output logic              BIST,
  output logic              CEBM,
  output logic              WEBM,
  output logic [ADDR_W-1:0] AM,
  output logic [DATA_W-1:0] DM,
  output logic [DATA_W-1:0] BWEBM,
  input  logic [DATA_W-1:0] Q
);

  localparam logic [ADDR_W-1:0] ADDR_LAST    = '1;
  localparam logic [DATA_W-1:0] PAT_CHK_EVEN = {(DATA_W/2){CHK_EVEN_PAIR}};

  state_t              state, state_nx;
  bg_t                 bg;
  logic [ELEM_W-1:0]   elem, elem_nx;
  logic                op;
  logic [ADDR_W-1:0]   addr;
  logic                start_acc, last_op, last_addr, last_elem, run_last;
  logic                rd_op, pol, rd_issue;
  logic [DATA_W-1:0]   pattern;

  assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
  assign rd_issue  = (state == ST_RUN) && rd_op;

  always_comb begin
    last_op   = ~ELEM_TWO[elem] | op;
    last_addr = ELEM_DOWN[elem] ? (addr == '0) : (addr == ADDR_LAST);
    last_elem = (elem == ELEM_W'(NUM_ELEMS - 1));
    elem_nx   = last_elem ? '0 : elem + 1'b1;
    run_last  = (bg == BG_CHECKER) && last_elem && last_addr && last_op;
    rd_op     = ~op & ELEM_RD0[elem];
    pol       = op ? ELEM_POL1[elem] : ELEM_POL0[elem];
  end

  always_comb begin
    if (bg == BG_SOLID) pattern = '0;
    else                pattern = addr[0] ? ~PAT_CHK_EVEN : PAT_CHK_EVEN;
    if (pol) pattern = ~pattern;
  end

  // Address only wraps at element ends; each new element reloads from its direction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bg   <= BG_SOLID;
      elem <= '0;
      op   <= 1'b0;
      addr <= '0;
    end else if (start_acc) begin
      bg   <= BG_SOLID;
      elem <= '0;
      op   <= 1'b0;
      addr <= '0;
    end else if (state == ST_RUN) begin
      if (!last_op) begin
        op <= 1'b1;
      end else begin
        op <= 1'b0;
        if (!last_addr) begin
          addr <= ELEM_DOWN[elem] ? addr - 1'b1 : addr + 1'b1;
        end else begin
          elem <= elem_nx;
          addr <= ELEM_DOWN[elem_nx] ? ADDR_LAST : '0;
          if (last_elem) bg <= BG_CHECKER;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_RUN;
      ST_RUN:           if (run_last) state_nx = ST_DRAIN;
      ST_DRAIN:         state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    BIST  = 1'b0;
    CEBM  = 1'b1;
    WEBM  = 1'b1;
    AM    = '0;
    DM    = '0;
    BWEBM = '1;
    case (state)
      ST_RUN: begin
        busy  = 1'b1;
        BIST  = 1'b1;
        CEBM  = 1'b0;
        WEBM  = rd_op;
        AM    = addr;
        DM    = pattern;
        BWEBM = '0;
      end
      ST_DRAIN: begin
        busy  = 1'b1;
        BIST  = 1'b1;
        BWEBM = '0;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  sram_mbist_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk      (CLK),
    .rst      (RST),
    .clr      (start_acc),
    .rd_issue (rd_issue),
    .exp_data (pattern),
    .exp_addr (addr),
    .q        (Q),
    .fail     (fail),
    .fail_addr(fail_addr),
    .fail_q   (fail_q)
  );

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// tb/tb_sram_mbist_ctrl.sv - scoreboard bench for the March C- SRAM BIST controller
module tb_sram_mbist_ctrl;

  localparam int BAW = 11;
  localparam int SAW = 4;
  localparam int DW  = 32;

  typedef struct packed {
    logic           we_n;
    logic [BAW-1:0] a;
    logic [DW-1:0]  d;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  logic start_b, start_s;
  logic sel;
  logic b_stuck_en, b_stuck2_en, b_cpl_en, s_stuck_en;
  int   checks = 0;
  int   errors = 0;
  op_t  opq[$];

  always #5 clk = ~clk;

  logic           b_busy, b_done, b_fail, b_bist, b_cebm, b_webm;
  logic [BAW-1:0] b_fail_addr, b_am;
  logic [DW-1:0]  b_fail_q, b_dm, b_bwebm, b_q;
  logic           s_busy, s_done, s_fail, s_bist, s_cebm, s_webm;
  logic [SAW-1:0] s_fail_addr, s_am;
  logic [DW-1:0]  s_fail_q, s_dm, s_bwebm, s_q;

  sram_mbist_ctrl #(.ADDR_W(BAW), .DATA_W(DW)) u_big (
    .CLK(clk), .RST(rst), .start(start_b), .busy(b_busy), .done(b_done), .fail(b_fail),
    .fail_addr(b_fail_addr), .fail_q(b_fail_q), .BIST(b_bist), .CEBM(b_cebm), .WEBM(b_webm),
    .AM(b_am), .DM(b_dm), .BWEBM(b_bwebm), .Q(b_q)
  );

  sram_mbist_ctrl #(.ADDR_W(SAW), .DATA_W(DW)) u_small (
    .CLK(clk), .RST(rst), .start(start_s), .busy(s_busy), .done(s_done), .fail(s_fail),
    .fail_addr(s_fail_addr), .fail_q(s_fail_q), .BIST(s_bist), .CEBM(s_cebm), .WEBM(s_webm),
    .AM(s_am), .DM(s_dm), .BWEBM(s_bwebm), .Q(s_q)
  );

  // Macro models: registered read data, masked writes, optional injected faults
  logic [DW-1:0] b_mem [0:(1<<BAW)-1];
  logic [DW-1:0] s_mem [0:(1<<SAW)-1];

  always @(posedge clk) begin
    if (!b_cebm) begin
      if (!b_webm) begin
        b_mem[b_am] <= (b_mem[b_am] & b_bwebm) | (b_dm & ~b_bwebm);
        if (b_cpl_en && b_am == 11'h010) b_mem[11'h011] <= b_mem[11'h011] ^ 32'h0000_0001;
      end else begin
        b_q <= b_mem[b_am]
             | ((b_stuck_en  && b_am == 11'h123) ? 32'h0000_0020 : 32'h0)
             | ((b_stuck2_en && b_am == 11'h400) ? 32'h0000_0008 : 32'h0);
      end
    end
  end

  always @(posedge clk) begin
    if (!s_cebm) begin
      if (!s_webm) s_mem[s_am] <= (s_mem[s_am] & s_bwebm) | (s_dm & ~s_bwebm);
      else s_q <= s_mem[s_am] | ((s_stuck_en && s_am == 4'h3) ? 32'h0000_0020 : 32'h0);
    end
  end

  logic           o_busy, o_done, o_fail, o_bist, o_cebm, o_webm;
  logic [BAW-1:0] o_fail_addr, o_am;
  logic [DW-1:0]  o_fail_q, o_dm, o_bwebm;

  always_comb begin
    if (sel) begin
      o_busy = s_busy; o_done = s_done; o_fail = s_fail; o_bist = s_bist;
      o_cebm = s_cebm; o_webm = s_webm; o_dm = s_dm; o_bwebm = s_bwebm; o_fail_q = s_fail_q;
      o_am = {{(BAW-SAW){1'b0}}, s_am};
      o_fail_addr = {{(BAW-SAW){1'b0}}, s_fail_addr};
    end else begin
      o_busy = b_busy; o_done = b_done; o_fail = b_fail; o_bist = b_bist;
      o_cebm = b_cebm; o_webm = b_webm; o_dm = b_dm; o_bwebm = b_bwebm; o_fail_q = b_fail_q;
      o_am = b_am;
      o_fail_addr = b_fail_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int bg, input int a, input int one);
    logic [DW-1:0] p;
    if (bg == 0) p = 32'h0000_0000;
    else         p = (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
    return (one != 0) ? ~p : p;
  endfunction

  task automatic gen_ops(input int aw);
    int n;
    int e_down [6] = '{0, 0, 0, 1, 1, 1};
    int e_nops [6] = '{1, 2, 2, 2, 2, 1};
    int e_rd0  [6] = '{0, 1, 1, 1, 1, 1};
    int e_v0   [6] = '{0, 0, 1, 0, 1, 0};
    int e_v1   [6] = '{0, 1, 0, 1, 0, 0};
    n = 1 << aw;
    opq.delete();
    for (int bg = 0; bg < 2; bg++)
      for (int e = 0; e < 6; e++)
        for (int i = 0; i < n; i++) begin
          int a;
          a = (e_down[e] != 0) ? n - 1 - i : i;
          opq.push_back('{we_n: (e_rd0[e] != 0), a: BAW'(a), d: pat(bg, a, e_v0[e])});
          if (e_nops[e] == 2) opq.push_back('{we_n: 1'b0, a: BAW'(a), d: pat(bg, a, e_v1[e])});
        end
  endtask

  task automatic pulse_start();
    if (sel) start_s = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic run_ops(input int n, input int pulse_at, output int cebm_low);
    op_t e;
    cebm_low = 0;
    for (int i = 0; i < n; i++) begin
      e = opq.pop_front();
      if (o_cebm == 1'b0) cebm_low++;
      checks++;
      assert (o_cebm === 1'b0 && o_webm === e.we_n && o_am === e.a && (e.we_n || o_dm === e.d)
              && o_bwebm === '0 && o_bist === 1'b1 && o_busy === 1'b1 && o_done === 1'b0)
      else begin
        errors++;
        $error("FAIL op%0d: observed cebm=%b webm=%b am=%0h dm=%0h busy=%b done=%b expected cebm=0 webm=%b am=%0h dm=%0h busy=1 done=0",
               i, o_cebm, o_webm, o_am, o_dm, o_busy, o_done, e.we_n, e.a, e.d);
      end
      if (i == pulse_at) begin
        if (sel) start_s = 1'b1; else start_b = 1'b1;
      end
      @(posedge clk); #1;
      start_s = 1'b0;
      start_b = 1'b0;
    end
  endtask

  task automatic finish_run(input string tag);
    check({tag, "_drain_cebm"}, o_cebm, 1);
    check({tag, "_drain_busy"}, o_busy, 1);
    check({tag, "_drain_done"}, o_done, 0);
    @(posedge clk); #1;
    check({tag, "_done"},  o_done, 1);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_bist"},  o_bist, 0);
    check({tag, "_cebm"},  o_cebm, 1);
    check({tag, "_webm"},  o_webm, 1);
    check({tag, "_bwebm"}, o_bwebm, 32'hFFFF_FFFF);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},      o_busy, 0);
    check({tag, "_done"},      o_done, 0);
    check({tag, "_fail"},      o_fail, 0);
    check({tag, "_fail_addr"}, o_fail_addr, 0);
    check({tag, "_fail_q"},    o_fail_q, 0);
    check({tag, "_bist"},      o_bist, 0);
    check({tag, "_cebm"},      o_cebm, 1);
    check({tag, "_webm"},      o_webm, 1);
    check({tag, "_am"},        o_am, 0);
    check({tag, "_dm"},        o_dm, 0);
    check({tag, "_bwebm"},     o_bwebm, 32'hFFFF_FFFF);
  endtask

  initial begin
    int lows;
    rst = 1'b1; start_b = 1'b0; start_s = 1'b0; sel = 1'b0;
    b_stuck_en = 1'b0; b_stuck2_en = 1'b0; b_cpl_en = 1'b0; s_stuck_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_big");
    sel = 1'b1;
    check_reset("rst_small");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset("idle_small");

    // 16-word instance, stuck-at-1 bit 5 at address 3
    s_stuck_en = 1'b1;
    gen_ops(SAW);
    pulse_start();
    run_ops(320, -1, lows);
    check("s1_cebm_low", lows, 320);
    finish_run("s1");
    check("s1_fail", o_fail, 1);
    check("s1_fail_addr", o_fail_addr, 11'h003);
    check("s1_fail_q", o_fail_q, 32'h0000_0020);

    // restart from DONE on a healthy array, with a start pulse mid-run
    s_stuck_en = 1'b0;
    gen_ops(SAW);
    pulse_start();
    check("s2_restart_done", o_done, 0);
    check("s2_restart_busy", o_busy, 1);
    check("s2_restart_fail", o_fail, 0);
    check("s2_restart_fail_addr", o_fail_addr, 0);
    check("s2_restart_fail_q", o_fail_q, 0);
    run_ops(320, 150, lows);
    check("s2_cebm_low", lows, 320);
    finish_run("s2");
    check("s2_fail", o_fail, 0);
    check("s2_fail_addr", o_fail_addr, 0);
    check("s2_fail_q", o_fail_q, 0);

    // 2048-word instance, stuck-at-1 bit 5 at 0x123, aborted by reset once captured
    sel = 1'b0;
    b_stuck_en = 1'b1;
    gen_ops(BAW);
    pulse_start();
    run_ops(3000, -1, lows);
    check("b1_fail", o_fail, 1);
    check("b1_fail_addr", o_fail_addr, 11'h123);
    check("b1_fail_q", o_fail_q, 32'h0000_0020);
    rst = 1'b1;
    #1;
    check_reset("b1_abort");
    @(posedge clk); #1;
    rst = 1'b0;
    b_stuck_en = 1'b0;
    @(posedge clk); #1;

    // reset during operation 1000
    gen_ops(BAW);
    pulse_start();
    run_ops(999, -1, lows);
    rst = 1'b1;
    #1;
    check_reset("rst_op1000");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // full run: coupling fault 0x010 -> 0x011 bit 0, plus a later fault at 0x400
    b_cpl_en = 1'b1;
    b_stuck2_en = 1'b1;
    gen_ops(BAW);
    pulse_start();
    run_ops(40960, 20000, lows);
    check("b2_cebm_low", lows, 40960);
    finish_run("b2");
    check("b2_fail", o_fail, 1);
    check("b2_fail_addr", o_fail_addr, 11'h011);
    check("b2_fail_q", o_fail_q, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
